stream_convolver: RTL and testbench

//  Streaming 2-D convolution engine for one feature map of the CNN datapath.

---
 rtl/stream_convolver.sv | 162 ++++++++++++++++
 tb/tb_stream_convolver.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/stream_convolver.sv
// stream_convolver: streaming KxK 2-D convolution over an MxM matrix fed in raster order.
//
// Each accepted pixel enters a tapped delay line long enough to hold K-1 full rows of the
// largest supported matrix plus K-1 pixels. The taps that form the current window are
// picked at run time from matrix_size_i. A chain of K*K multiply-accumulate stages sums
// the window, and the result is registered. A result is flagged valid one cycle after
// the pixel that completes a stride-aligned window is accepted.
//
// Ports:
//   clk_i, rst_ni    clock and synchronous active-low reset
//   en_i             accept data_i and advance; low = full stall
//   data_i           signed pixel, row-major
//   stride_i         window stride (0 behaves as 1)
//   matrix_size_i    matrix side M, K <= M <= MaxMatrixSize
//   weights_i        signed kernel, weights_i[K*r+c]
//   conv_o           signed 2N-bit result, held between valid pulses
//   valid_conv_o     one-cycle pulse per strided window result
//   end_conv_o       sticky once all M*M pixels have been processed
//   assert_on_i      enables runtime configuration checks
//
// Optional build macro STREAM_CONVOLVER_ASSERT_EN compiles in the configuration checks;
// without it assert_on_i is ignored. The datapath is the same in both builds.
module stream_convolver #(
  parameter int unsigned MaxMatrixSize = 10,
  parameter int unsigned KernelSize    = 3,
  parameter int unsigned N             = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               en_i,
  input  logic signed [N-1:0]                data_i,
  input  logic [5:0]                         stride_i,
  input  logic [13:0]                        matrix_size_i,
  input  logic [KernelSize*KernelSize-1:0][N-1:0] weights_i,
  output logic signed [2*N-1:0]              conv_o,
  output logic                               valid_conv_o,
  output logic                               end_conv_o,
  input  logic                               assert_on_i
);

  localparam int unsigned K     = KernelSize;
  localparam int unsigned Taps  = (K - 1) * MaxMatrixSize + K - 1;
  localparam int unsigned AW    = $clog2(Taps);
  localparam int unsigned WIdxW = $clog2(K * K);
  localparam logic [13:0] Km1   = 14'(K - 1);
  localparam logic [13:0] MaxM  = 14'(MaxMatrixSize);

  logic signed [N-1:0]   sr_q [Taps];
  logic [13:0]           row_q, row_d, col_q, col_d;
  logic [5:0]            cph_q, cph_d, rph_q, rph_d;
  logic                  done_q, done_d, end_q;
  logic                  valid_q, valid_d;
  logic signed [2*N-1:0] conv_q, conv_d;

  logic                  take, hit, last_col, last_px;
  logic [13:0]           eff_m;
  logic [6:0]            s_eff, cph_inc, rph_inc;
  logic [5:0]            cur_cph, cur_rph;
  logic signed [2*N-1:0] acc;
  logic [13:0]           off;
  logic signed [N-1:0]   px, wt;
  logic [WIdxW-1:0]      widx;

  // Out-of-range sizes are clamped so tap selection never leaves the delay line.
  assign eff_m = (matrix_size_i > MaxM) ? MaxM : matrix_size_i;

  // MAC chain: window element (r,c) lies (K-1-r)*M + (K-1-c) pixels behind the newest one.
  always_comb begin
    acc  = '0;
    off  = '0;
    px   = '0;
    wt   = '0;
    widx = '0;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) begin
        off  = 14'(K - 1 - r) * eff_m + 14'(K - 1 - c);
        px   = (off == 14'd0) ? data_i : sr_q[AW'(off - 14'd1)];
        widx = WIdxW'(K * r + c);
        wt   = $signed(weights_i[widx]);
        acc  = acc + (2*N)'(px) * (2*N)'(wt);
      end
    end
  end

  // Stride phases restart at the first full-window column/row, so R%S and C%S need no divider.
  always_comb begin
    take     = en_i && !done_q;
    s_eff    = (stride_i == 6'd0) ? 7'd1 : {1'b0, stride_i};
    last_col = (col_q == eff_m - 14'd1);
    last_px  = last_col && (row_q == eff_m - 14'd1);
    cur_cph  = (col_q == Km1) ? 6'd0 : cph_q;
    cur_rph  = (row_q == Km1) ? 6'd0 : rph_q;
    cph_inc  = {1'b0, cur_cph} + 7'd1;
    rph_inc  = {1'b0, cur_rph} + 7'd1;
    hit      = take && (row_q >= Km1) && (col_q >= Km1) &&
               (cur_cph == 6'd0) && (cur_rph == 6'd0);

    col_d  = col_q;
    row_d  = row_q;
    cph_d  = cph_q;
    rph_d  = rph_q;
    done_d = done_q;
    if (take) begin
      col_d = last_col ? 14'd0 : col_q + 14'd1;
      if (last_col) row_d = row_q + 14'd1;
      if (col_q >= Km1) cph_d = (cph_inc == s_eff) ? 6'd0 : cph_inc[5:0];
      if (last_col && row_q >= Km1) rph_d = (rph_inc == s_eff) ? 6'd0 : rph_inc[5:0];
      if (last_px) done_d = 1'b1;
    end
    valid_d = hit;
    conv_d  = hit ? acc : conv_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Taps; i++) sr_q[i] <= '0;
      row_q   <= '0;
      col_q   <= '0;
      cph_q   <= '0;
      rph_q   <= '0;
      done_q  <= 1'b0;
      end_q   <= 1'b0;
      valid_q <= 1'b0;
      conv_q  <= '0;
    end else begin
      if (take) begin
        sr_q[0] <= data_i;
        for (int unsigned i = 1; i < Taps; i++) sr_q[i] <= sr_q[i-1];
      end
      row_q   <= row_d;
      col_q   <= col_d;
      cph_q   <= cph_d;
      rph_q   <= rph_d;
      done_q  <= done_d;
      // Lags done_q by one cycle so it rises just after the final result pulse.
      end_q   <= done_q;
      valid_q <= valid_d;
      conv_q  <= conv_d;
    end
  end

  assign conv_o       = conv_q;
  assign valid_conv_o = valid_q;
  assign end_conv_o   = end_q;

`ifdef STREAM_CONVOLVER_ASSERT_EN
  always_ff @(posedge clk_i) begin
    if (assert_on_i) begin
      if (!(K > 1)) $error("stream_convolver: KernelSize must exceed 1");
      if (!(N > 0)) $error("stream_convolver: N must be positive");
      if (!(matrix_size_i >= 14'(K) && matrix_size_i <= MaxM))
        $error("stream_convolver: matrix_size_i %0d out of range", matrix_size_i);
      if (!({8'd0, stride_i} < matrix_size_i))
        $error("stream_convolver: stride_i %0d not below matrix size", stride_i);
    end
  end
`else
  logic unused_assert_on;
  assign unused_assert_on = assert_on_i;
`endif

endmodule

// File: tb/tb_stream_convolver.sv
module tb_stream_convolver;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic signed [15:0] data;
  logic [5:0]         stride;
  logic [13:0]        msize;
  logic [8:0][15:0]   weights;
  logic signed [31:0] conv;
  logic               valid;
  logic               endc;
  logic               aon;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;
  bit          stall_chk;

  stream_convolver #(
    .MaxMatrixSize(10),
    .KernelSize   (3),
    .N            (16)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .data_i       (data),
    .stride_i     (stride),
    .matrix_size_i(msize),
    .weights_i    (weights),
    .conv_o       (conv),
    .valid_conv_o (valid),
    .end_conv_o   (endc),
    .assert_on_i  (aon)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse: got %0h, expected no pulse", conv);
      end else begin
        last_exp = exp_q.pop_front();
        check("conv_value", conv, last_exp);
      end
    end
  end

  // Mode 0: weights 0..8, pixel k = k. Mode 1: weights -1, pixels 100.
  task automatic do_reset(input int m, input int s, input int mode);
    @(posedge clk); #1;
    rst_n  = 1'b0;
    en     = 1'b0;
    msize  = 14'(m);
    stride = 6'(s);
    for (int i = 0; i < 9; i++) weights[i] = (mode == 0) ? 16'(i) : 16'hFFFF;
    @(posedge clk); #1;
    check("reset_conv", conv, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_end", {31'd0, endc}, 32'd0);
    check("reset_queue_empty", exp_q.size(), 32'd0);
    exp_q.delete();
    last_exp  = 32'd0;
    stall_chk = 1'b0;
    rst_n     = 1'b1;
  endtask

  task automatic run(input int m, input int s, input int mode, input int npix,
                     input bit stalls, input bit pad);
    int r, c, se;
    se = (s == 0) ? 1 : s;
    for (int k = 0; k < npix; k++) begin
      if (stalls && (k == 5 || k == 30)) begin
        for (int i = 0; i < 3; i++) begin
          @(posedge clk); #1;
          if (stall_chk) begin
            check("stall_valid", {31'd0, valid}, 32'd0);
            check("stall_hold", conv, last_exp);
          end
          en        = 1'b0;
          stall_chk = 1'b1;
        end
      end
      @(posedge clk); #1;
      if (stall_chk) begin
        check("stall_valid", {31'd0, valid}, 32'd0);
        check("stall_hold", conv, last_exp);
        stall_chk = 1'b0;
      end
      en   = 1'b1;
      data = (mode == 0) ? 16'(k) : 16'sd100;
      r    = k / m;
      c    = k % m;
      if (r >= 2 && c >= 2 && (r - 2) % se == 0 && (c - 2) % se == 0)
        exp_q.push_back((mode == 0) ? 32'(474 + 288 * (r - 2) + 36 * (c - 2)) : 32'hFFFFFC7C);
    end
    if (pad) begin
      @(posedge clk); #1;
      check("end_not_yet", {31'd0, endc}, 32'd0);
      data = 16'sd7;
      @(posedge clk); #1;
      check("end_rise", {31'd0, endc}, 32'd1);
      @(posedge clk); #1;
      en = 1'b0;
      @(posedge clk); #1;
      check("end_sticky", {31'd0, endc}, 32'd1);
      check("all_results_seen", exp_q.size(), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    data  = '0;
    aon   = 1'b1;
    // Stride 1, full sequence 474..2094.
    do_reset(8, 1, 0);
    run(8, 1, 0, 64, 1'b0, 1'b1);
    // Stride 2: nine results.
    do_reset(8, 2, 0);
    run(8, 2, 0, 64, 1'b0, 1'b1);
    // Stalls before pixels 5 and 30.
    do_reset(8, 1, 0);
    run(8, 1, 0, 64, 1'b1, 1'b1);
    // Stride 0 behaves like stride 1, aborted mid-matrix by reset, then a full restart.
    do_reset(8, 0, 0);
    run(8, 0, 0, 20, 1'b0, 1'b0);
    do_reset(8, 1, 0);
    run(8, 1, 0, 64, 1'b0, 1'b1);
    // Minimum matrix, negative weights: single -900 result.
    do_reset(3, 1, 1);
    run(3, 1, 1, 9, 1'b0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
